alu_wide_seq: RTL and testbench
===============================

# alu_wide_seq

Double-width ALU sequencer. Accepts one 2W-bit arithmetic/logic request over a valid/ready handshake and drives the existing W-bit ALU twice, low half then high half. Carry is chained between the halves and Z is merged. The block is the initiator side of the ALU's oper / a_in / b_in / proc_flags_in → out / proc_flags_out interface and sits between the control unit and the ALU for 32-bit ops.

## Interface
Parameters:
- W, `alu_inout_width` (16): ALU word width; request operands are 2W.
- FW, `proc_flags_msb_pos`+1: processor flags width; C at pkg_pflags::pf_slot_c, Z at pkg_pflags::pf_slot_z.

Ports:
- clk  in  1  clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on a clk edge with req_valid=1.
- req_oper  in  pkg_alu::alu_op  requested operation.
- req_a, req_b  in  2W  operands.
- req_flags  in  FW  current processor flags.
- alu_oper  out  pkg_alu::alu_op  to ALU oper.
- alu_a, alu_b  out  W  to ALU a_in/b_in.
- alu_flags_in  out  FW  to ALU proc_flags_in.
- alu_out  in  W  from ALU out.
- alu_flags_out  in  FW  from ALU proc_flags_out; only C and Z are sampled.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_result  out  2W  result.
- rsp_flags  out  FW  resulting flags.
- rsp_err  out  1  unsupported op; no computation performed.

## Operation
- FSM states: IDLE, LO, HI, RSP. Reset state is IDLE.
- IDLE: req_ready=1.
  - Accept with a supported op: capture operands, op and flags, then go to LO.
  - Accept with an unsupported op: set rsp_result=req_a, rsp_flags=req_flags, rsp_err=1, then go to RSP.
- Supported ops: add, adc, sub, sbc, cmp, and, orr, xor. Shifts, rotates and any other code are unsupported.
- LO: drive the ALU with the low halves, alu_flags_in = captured flags.
  - Low-half op is the requested op unchanged.
  - Capture alu_out as res_lo, and C and Z as c_lo and z_lo; go to HI.
- HI: drive the ALU with the high halves, alu_flags_in = captured flags with C replaced by c_lo.
  - High-half op: add/adc→adc; sub/sbc/cmp→sbc; and/orr/xor unchanged.
  - Capture res_hi; go to RSP.
- RSP: rsp_valid=1; all rsp_* outputs are held stable. rsp_ready=1 returns the FSM to IDLE.
- Result:
  - cmp: rsp_result = captured req_a.
  - All other ops: rsp_result = {res_hi, res_lo}.
- Flags: rsp_flags = captured flags with C = high-half C and Z = z_lo & high-half Z.
  - Logic ops leave C equal to the captured C, because the ALU passes C through.
  - All non-C/Z bits are unchanged.
- ALU drive in IDLE and RSP: alu_oper=pkg_alu::alu_op_add, alu_a=alu_b=0, alu_flags_in=0.
- The ALU is combinational; the block registers nothing on the ALU inputs.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - rsp_valid=0, rsp_err=0, rsp_result=0, rsp_flags=0.
  - The in-flight operation is discarded.

## Timing
- Supported op: accepted at edge N. The state is LO during cycle N→N+1 and HI during N+1→N+2. rsp_valid=1 from edge N+2.
- Unsupported op: rsp_valid=1 from edge N+1.
- Without pipelining, the minimum request period is 4 cycles: accept, LO, HI, RSP with rsp_ready=1.
- req_ready is 0 in LO, HI and RSP (see Configuration).
- rsp_valid stays asserted until a clk edge samples rsp_ready=1. An arbitrarily long stall is allowed.

## Configuration
- Macro: ALU_WIDE_SEQ_PIPE_EN.
- Defined:
  - In RSP, req_ready = rsp_ready.
  - A response handoff and a new request accept may occur on the same edge; the FSM goes directly RSP→LO (or RSP→RSP for an unsupported op).
  - Period is 3 cycles.
- Undefined: req_ready=1 only in IDLE; period is 4 cycles.

## Test plan
- add 0x0000FFFF + 0x00000001, flags C=0 → ALU sees add(0xFFFF,0x0001) then adc(0x0000,0x0000,C=1). Required response: result 0x00010000, C=0, Z=0, rsp_valid 2 cycles after accept.
- sub 0x00010000 − 0x00000001 → result 0x0000FFFF, C=1, Z=0; high-half oper = sbc.
- cmp 0x12345678 vs 0x12345678 → result 0x12345678, Z=1, C=1.
- xor 0xFFFF0000 ^ 0xFFFF0000 with req_flags C=1 → result 0x00000000, Z=1, C=1.
- lsl request, a=0xDEADBEEF → rsp_err=1, result 0xDEADBEEF, flags equal req_flags, rsp_valid 1 cycle after accept, ALU never driven off idle values.
- Two cases:
  - Hold rsp_ready=0 for 5 cycles → response stable and req_ready=0; with PIPE_EN, releasing rsp_ready with req_valid=1 accepts on the same edge.
  - Assert reset_n=0 in HI → rsp_valid=0 and state IDLE immediately, with no response emitted.

Source files
------------

// File: rtl/alu_wide_seq.sv
// Double-width ALU sequencer: runs one 2W-bit request through a W-bit ALU, low half then high half.
// Optional macro ALU_WIDE_SEQ_PIPE_EN lets a response handoff and a new accept share one edge.

package pkg_alu;
    localparam int unsigned alu_inout_width = 16;

    typedef enum logic [3:0] {
        alu_op_add = 4'd0,
        alu_op_adc = 4'd1,
        alu_op_sub = 4'd2,
        alu_op_sbc = 4'd3,
        alu_op_cmp = 4'd4,
        alu_op_and = 4'd5,
        alu_op_orr = 4'd6,
        alu_op_xor = 4'd7,
        alu_op_lsl = 4'd8,
        alu_op_lsr = 4'd9,
        alu_op_asr = 4'd10,
        alu_op_rol = 4'd11,
        alu_op_ror = 4'd12
    } alu_op;
endpackage

package pkg_pflags;
    localparam int unsigned proc_flags_msb_pos = 3;
    localparam int unsigned pf_slot_z = 0;
    localparam int unsigned pf_slot_c = 1;
    localparam int unsigned pf_slot_n = 2;
    localparam int unsigned pf_slot_v = 3;
endpackage

module alu_wide_seq #(
    parameter int unsigned W  = pkg_alu::alu_inout_width,
    parameter int unsigned FW = pkg_pflags::proc_flags_msb_pos + 1
) (
    input  logic           clk,
    input  logic           reset_n,

    input  logic           req_valid,
    output logic           req_ready,
    input  pkg_alu::alu_op req_oper,
    input  logic [2*W-1:0] req_a,
    input  logic [2*W-1:0] req_b,
    input  logic [FW-1:0]  req_flags,

    output pkg_alu::alu_op alu_oper,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [FW-1:0]  alu_flags_in,
    input  logic [W-1:0]   alu_out,
    input  logic [FW-1:0]  alu_flags_out,

    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*W-1:0] rsp_result,
    output logic [FW-1:0]  rsp_flags,
    output logic           rsp_err
);
    import pkg_alu::*;

    localparam int unsigned SlotC = pkg_pflags::pf_slot_c;
    localparam int unsigned SlotZ = pkg_pflags::pf_slot_z;

    typedef enum logic [1:0] {StIdle, StLo, StHi, StRsp} state_e;

    function automatic logic op_supported(input alu_op op);
        case (op)
            alu_op_add, alu_op_adc, alu_op_sub, alu_op_sbc, alu_op_cmp,
            alu_op_and, alu_op_orr, alu_op_xor: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // The high half continues the carry/borrow chain started by the low half.
    function automatic alu_op hi_half_op(input alu_op op);
        case (op)
            alu_op_add, alu_op_adc:             return alu_op_adc;
            alu_op_sub, alu_op_sbc, alu_op_cmp: return alu_op_sbc;
            default:                            return op;
        endcase
    endfunction

    state_e         state_q, state_d;
    alu_op          op_q, op_d;
    logic [2*W-1:0] a_q, a_d;
    logic [2*W-1:0] b_q, b_d;
    logic [FW-1:0]  flags_q, flags_d;
    logic [W-1:0]   res_lo_q, res_lo_d;
    logic           c_lo_q, c_lo_d;
    logic           z_lo_q, z_lo_d;
    logic [2*W-1:0] result_q, result_d;
    logic [FW-1:0]  rflags_q, rflags_d;
    logic           err_q, err_d;
    logic [FW-1:0]  hi_flags;
    logic           accept;

    // Only C and Z of the ALU flags are consumed.
    logic unused_alu_flags;
    assign unused_alu_flags = ^alu_flags_out;

`ifdef ALU_WIDE_SEQ_PIPE_EN
    assign req_ready = (state_q == StIdle) || ((state_q == StRsp) && rsp_ready);
`else
    assign req_ready = (state_q == StIdle);
`endif

    assign accept     = req_valid && req_ready;
    assign rsp_valid  = (state_q == StRsp);
    assign rsp_result = result_q;
    assign rsp_flags  = rflags_q;
    assign rsp_err    = err_q;

    always_comb begin
        hi_flags        = flags_q;
        hi_flags[SlotC] = c_lo_q;
    end

    always_comb begin
        alu_oper     = alu_op_add;
        alu_a        = '0;
        alu_b        = '0;
        alu_flags_in = '0;
        unique case (state_q)
            StLo: begin
                alu_oper     = op_q;
                alu_a        = a_q[W-1:0];
                alu_b        = b_q[W-1:0];
                alu_flags_in = flags_q;
            end
            StHi: begin
                alu_oper     = hi_half_op(op_q);
                alu_a        = a_q[2*W-1:W];
                alu_b        = b_q[2*W-1:W];
                alu_flags_in = hi_flags;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        flags_d  = flags_q;
        res_lo_d = res_lo_q;
        c_lo_d   = c_lo_q;
        z_lo_d   = z_lo_q;
        result_d = result_q;
        rflags_d = rflags_q;
        err_d    = err_q;

        unique case (state_q)
            StIdle: begin
            end
            StLo: begin
                res_lo_d = alu_out;
                c_lo_d   = alu_flags_out[SlotC];
                z_lo_d   = alu_flags_out[SlotZ];
                state_d  = StHi;
            end
            StHi: begin
                result_d        = (op_q == alu_op_cmp) ? a_q : {alu_out, res_lo_q};
                rflags_d        = flags_q;
                rflags_d[SlotC] = alu_flags_out[SlotC];
                rflags_d[SlotZ] = z_lo_q & alu_flags_out[SlotZ];
                err_d           = 1'b0;
                state_d         = StRsp;
            end
            StRsp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // An accept overrides the RSP->IDLE return when handoff and accept share an edge.
        if (accept) begin
            if (op_supported(req_oper)) begin
                op_d    = req_oper;
                a_d     = req_a;
                b_d     = req_b;
                flags_d = req_flags;
                state_d = StLo;
            end else begin
                result_d = req_a;
                rflags_d = req_flags;
                err_d    = 1'b1;
                state_d  = StRsp;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            op_q     <= alu_op_add;
            a_q      <= '0;
            b_q      <= '0;
            flags_q  <= '0;
            res_lo_q <= '0;
            c_lo_q   <= 1'b0;
            z_lo_q   <= 1'b0;
            result_q <= '0;
            rflags_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            flags_q  <= flags_d;
            res_lo_q <= res_lo_d;
            c_lo_q   <= c_lo_d;
            z_lo_q   <= z_lo_d;
            result_q <= result_d;
            rflags_q <= rflags_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Bench for alu_wide_seq: behavioural W-bit ALU plus a whole-width 2W-bit reference model.
// Honours ALU_WIDE_SEQ_PIPE_EN when checking the back-to-back handoff.

module tb_alu_wide_seq;
    import pkg_alu::*;

    localparam int unsigned W  = 16;
    localparam int unsigned FW = 4;
    localparam int unsigned SC = pkg_pflags::pf_slot_c;
    localparam int unsigned SZ = pkg_pflags::pf_slot_z;
    localparam logic [39:0] IdleDrv = {alu_op_add, 36'h0};

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    alu_op         req_oper;
    logic [31:0]   req_a;
    logic [31:0]   req_b;
    logic [3:0]    req_flags;
    alu_op         alu_oper;
    logic [15:0]   alu_a;
    logic [15:0]   alu_b;
    logic [3:0]    alu_flags_in;
    logic [15:0]   alu_out;
    logic [3:0]    alu_flags_out;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_result;
    logic [3:0]    rsp_flags;
    logic          rsp_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_wide_seq #(.W(W), .FW(FW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_oper      (req_oper),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_flags     (req_flags),
        .alu_oper      (alu_oper),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_flags_in  (alu_flags_in),
        .alu_out       (alu_out),
        .alu_flags_out (alu_flags_out),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_flags     (rsp_flags),
        .rsp_err       (rsp_err)
    );

    // Combinational W-bit ALU; N/V come back inverted so any leak into the response shows.
    logic [16:0] alu_sum;
    logic [16:0] alu_cin;
    always_comb begin
        alu_cin = {16'h0, alu_flags_in[SC]};
        case (alu_oper)
            alu_op_add:             alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
            alu_op_adc:             alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + alu_cin;
            alu_op_sub, alu_op_cmp: alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
            alu_op_sbc:             alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + alu_cin;
            alu_op_and:             alu_sum = {alu_flags_in[SC], alu_a & alu_b};
            alu_op_orr:             alu_sum = {alu_flags_in[SC], alu_a | alu_b};
            alu_op_xor:             alu_sum = {alu_flags_in[SC], alu_a ^ alu_b};
            default:                alu_sum = {alu_flags_in[SC], alu_a};
        endcase
        alu_out           = alu_sum[15:0];
        alu_flags_out     = ~alu_flags_in;
        alu_flags_out[SC] = alu_sum[16];
        alu_flags_out[SZ] = (alu_sum[15:0] == 16'h0);
    end

    // Whole 32-bit operation computed in one go.
    function automatic void ref_model(input alu_op op, input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] f, output logic [31:0] res,
                                      output logic [3:0] fo, output logic err);
        logic [32:0] s;
        logic [32:0] ci;
        ci  = {32'h0, f[SC]};
        s   = '0;
        err = 1'b0;
        case (op)
            alu_op_add:             s = {1'b0, a} + {1'b0, b};
            alu_op_adc:             s = {1'b0, a} + {1'b0, b} + ci;
            alu_op_sub, alu_op_cmp: s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            alu_op_sbc:             s = {1'b0, a} + {1'b0, ~b} + ci;
            alu_op_and:             s = {f[SC], a & b};
            alu_op_orr:             s = {f[SC], a | b};
            alu_op_xor:             s = {f[SC], a ^ b};
            default:                err = 1'b1;
        endcase
        fo  = f;
        res = (err || op == alu_op_cmp) ? a : s[31:0];
        if (!err) begin
            fo[SC] = s[32];
            fo[SZ] = (s[31:0] == 32'h0);
        end
    endfunction

    function automatic logic lo_carry(input alu_op op, input logic [15:0] a, input logic [15:0] b,
                                      input logic ci);
        logic [16:0] s;
        case (op)
            alu_op_add:             s = {1'b0, a} + {1'b0, b};
            alu_op_adc:             s = {1'b0, a} + {1'b0, b} + {16'h0, ci};
            alu_op_sub, alu_op_cmp: s = {1'b0, a} + {1'b0, ~b} + 17'd1;
            alu_op_sbc:             s = {1'b0, a} + {1'b0, ~b} + {16'h0, ci};
            default:                s = {ci, 16'h0};
        endcase
        return s[16];
    endfunction

    function automatic alu_op exp_hi_op(input alu_op op);
        if (op == alu_op_add || op == alu_op_adc) return alu_op_adc;
        if (op == alu_op_sub || op == alu_op_sbc || op == alu_op_cmp) return alu_op_sbc;
        return op;
    endfunction

    // One full transaction, accept through handoff, with `stall` cycles of rsp_ready=0 in RSP.
    task automatic run_op(input alu_op op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] f, input int stall);
        logic [31:0] er;
        logic [3:0]  ef;
        logic        ee;
        logic [3:0]  hf;
        logic [39:0] exp_drv;
        logic [37:0] exp_rsp;
        ref_model(op, a, b, f, er, ef, ee);
        hf     = f;
        hf[SC] = lo_carry(op, a[15:0], b[15:0], f[SC]);
        exp_rsp = {1'b1, ee, er, ef};

        @(negedge clk);
        req_valid = 1'b1; req_oper = op; req_a = a; req_b = b; req_flags = f;
        n_chk++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready_idle op=%0d: got %b want 1", op, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0; req_a = $urandom(); req_b = $urandom(); req_flags = 4'($urandom());
        if (!ee) begin
            exp_drv = {op, a[15:0], b[15:0], f};
            n_chk++;
            if ({alu_oper, alu_a, alu_b, alu_flags_in, rsp_valid, req_ready} !== {exp_drv, 2'b00}) begin
                n_fail++;
                $display("FAIL lo_drive op=%0d: got %h want %h", op,
                         {alu_oper, alu_a, alu_b, alu_flags_in, rsp_valid, req_ready}, {exp_drv, 2'b00});
            end
            @(negedge clk);
            exp_drv = {exp_hi_op(op), a[31:16], b[31:16], hf};
            n_chk++;
            if ({alu_oper, alu_a, alu_b, alu_flags_in, rsp_valid, req_ready} !== {exp_drv, 2'b00}) begin
                n_fail++;
                $display("FAIL hi_drive op=%0d: got %h want %h", op,
                         {alu_oper, alu_a, alu_b, alu_flags_in, rsp_valid, req_ready}, {exp_drv, 2'b00});
            end
            @(negedge clk);
        end
        n_chk++;
        if ({rsp_valid, rsp_err, rsp_result, rsp_flags} !== exp_rsp) begin
            n_fail++;
            $display("FAIL response op=%0d a=%h b=%h f=%h: got %h want %h", op, a, b, f,
                     {rsp_valid, rsp_err, rsp_result, rsp_flags}, exp_rsp);
        end
        n_chk++;
        if ({alu_oper, alu_a, alu_b, alu_flags_in, req_ready} !== {IdleDrv, 1'b0}) begin
            n_fail++;
            $display("FAIL rsp_idle_drive op=%0d: got %h want %h", op,
                     {alu_oper, alu_a, alu_b, alu_flags_in, req_ready}, {IdleDrv, 1'b0});
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            n_chk++;
            if ({rsp_valid, rsp_err, rsp_result, rsp_flags, req_ready} !== {exp_rsp, 1'b0}) begin
                n_fail++;
                $display("FAIL rsp_stall op=%0d cyc=%0d: got %h want %h", op, i,
                         {rsp_valid, rsp_err, rsp_result, rsp_flags, req_ready}, {exp_rsp, 1'b0});
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_chk++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL handoff op=%0d: got %b want 01", op, {rsp_valid, req_ready});
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++;
        if ({rsp_valid, rsp_err, rsp_result, rsp_flags, req_ready} !== {38'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h",
                     {rsp_valid, rsp_err, rsp_result, rsp_flags, req_ready}, {38'h0, 1'b1});
        end
        n_chk++;
        if ({alu_oper, alu_a, alu_b, alu_flags_in} !== IdleDrv) begin
            n_fail++;
            $display("FAIL reset_alu_drive: got %h want %h",
                     {alu_oper, alu_a, alu_b, alu_flags_in}, IdleDrv);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        run_op(alu_op_add, 32'h0000FFFF, 32'h00000001, 4'h0, 0);
        run_op(alu_op_sub, 32'h00010000, 32'h00000001, 4'h0, 1);
        run_op(alu_op_cmp, 32'h12345678, 32'h12345678, 4'h0, 0);
        run_op(alu_op_xor, 32'hFFFF0000, 32'hFFFF0000, 4'h2, 0);
        run_op(alu_op_lsl, 32'hDEADBEEF, 32'h00000004, 4'hA, 2);
    endtask

    task automatic test_random();
        alu_op       op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
            op = alu_op'(4'($urandom_range(0, 15)));
            a  = $urandom();
            b  = $urandom();
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 5) == 0) a = 32'hFFFFFFFF;
            run_op(op, a, b, 4'($urandom()), $urandom_range(0, 3));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, er;
        logic [3:0]  f1, f2, ef;
        logic        ee;
        logic [37:0] exp_rsp;
        a1 = $urandom(); b1 = $urandom(); f1 = 4'($urandom());
        a2 = $urandom(); b2 = $urandom(); f2 = 4'($urandom());
        ref_model(alu_op_add, a1, b1, f1, er, ef, ee);
        exp_rsp = {1'b1, ee, er, ef};

        @(negedge clk);
        req_valid = 1'b1; req_oper = alu_op_add; req_a = a1; req_b = b1; req_flags = f1;
        @(negedge clk);
        req_oper = alu_op_sub; req_a = a2; req_b = b2; req_flags = f2;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if ({rsp_valid, rsp_err, rsp_result, rsp_flags, req_ready} !== {exp_rsp, 1'b0}) begin
                n_fail++;
                $display("FAIL b2b_stall cyc=%0d: got %h want %h", i,
                         {rsp_valid, rsp_err, rsp_result, rsp_flags, req_ready}, {exp_rsp, 1'b0});
            end
            if (i < 4) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
`ifndef ALU_WIDE_SEQ_PIPE_EN
        n_chk++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_idle: got %b want 01", {rsp_valid, req_ready});
        end
        @(negedge clk);
`endif
        req_valid = 1'b0;
        n_chk++;
        if ({alu_oper, alu_a, alu_b, alu_flags_in, rsp_valid} !==
            {alu_op_sub, a2[15:0], b2[15:0], f2, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_second_lo: got %h want %h", {alu_oper, alu_a, alu_b, alu_flags_in, rsp_valid},
                     {alu_op_sub, a2[15:0], b2[15:0], f2, 1'b0});
        end
        @(negedge clk);
        @(negedge clk);
        ref_model(alu_op_sub, a2, b2, f2, er, ef, ee);
        exp_rsp = {1'b1, ee, er, ef};
        n_chk++;
        if ({rsp_valid, rsp_err, rsp_result, rsp_flags} !== exp_rsp) begin
            n_fail++;
            $display("FAIL b2b_second_rsp: got %h want %h",
                     {rsp_valid, rsp_err, rsp_result, rsp_flags}, exp_rsp);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_in_hi();
        @(negedge clk);
        req_valid = 1'b1; req_oper = alu_op_adc; req_a = 32'h1234FFFF; req_b = 32'h00010001;
        req_flags = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_chk++;
        if ({rsp_valid, req_ready, rsp_err, rsp_result, rsp_flags} !== {1'b0, 1'b1, 37'h0}) begin
            n_fail++;
            $display("FAIL reset_in_hi_outputs: got %h want %h",
                     {rsp_valid, req_ready, rsp_err, rsp_result, rsp_flags}, {1'b0, 1'b1, 37'h0});
        end
        n_chk++;
        if ({alu_oper, alu_a, alu_b, alu_flags_in} !== IdleDrv) begin
            n_fail++;
            $display("FAIL reset_in_hi_alu: got %h want %h", {alu_oper, alu_a, alu_b, alu_flags_in}, IdleDrv);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if ({rsp_valid, req_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL reset_in_hi_quiet cyc=%0d: got %b want 01", i, {rsp_valid, req_ready});
            end
        end
        run_op(alu_op_orr, 32'h00F0000F, 32'h0F000F00, 4'h3, 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_oper  = alu_op_add;
        req_a     = '0;
        req_b     = '0;
        req_flags = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_in_hi();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
